music_player: RTL and testbench

Parametrised, score-driven tone sequencer for the game's audio path. It generates a square-wave `beep` from a 5-bit note code and a per-note beat count, both read from an external synchronous score ROM. It supports start/stop control, a selectable song base address, loop mode and a done pulse. Everything runs in one clock domain using clock-enable counters; no derived clocks.

---
 rtl/music_player_if.sv | 25 ++
 rtl/music_player.sv | 141 ++++++++++++++
 tb/tb_music_player.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/music_player_if.sv
// Music player bus: playback control, score ROM port and audio status.
interface music_player_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] song_base;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              beep;
  logic              busy;
  logic              done;
  logic [4:0]        cur_note;

  modport master (
    output start, stop, loop_en, song_base, rom_data,
    input  rom_addr, beep, busy, done, cur_note
  );

  modport slave (
    input  start, stop, loop_en, song_base, rom_data,
    output rom_addr, beep, busy, done, cur_note
  );
endinterface

// File: rtl/music_player.sv
// Score-driven square-wave tone sequencer reading {note, dur} words
// from a synchronous ROM, with loop, restart and stop control.
module music_player #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 4,
  parameter int ADDR_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  music_player_if.slave bus
);
  localparam int BEAT_CYC = CLK_HZ / TICK_HZ;
  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] PLAY = 2'd3;

  localparam logic [4:0] END_NOTE = 5'd31;

  localparam int FREQ [32] = '{
    0,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  // Zero entries mark rests and unused codes.
  logic [31:0] half_tab [32];

  for (genvar g = 0; g < 32; g++) begin : g_half
    if (FREQ[g] == 0) begin : g_rest
      assign half_tab[g] = 32'd0;
    end else begin : g_tone
      assign half_tab[g] = 32'(CLK_HZ / (2 * FREQ[g]));
    end
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        note_q;
  logic [3:0]        beats_left;
  logic [31:0]       beat_cnt;
  logic [31:0]       tone_cnt;
  logic [31:0]       half_q;
  logic              beep_q;
  logic              done_q;

  logic [4:0] note_in;
  logic [2:0] dur_in;

  assign note_in = bus.rom_data[7:3];
  assign dur_in  = bus.rom_data[2:0];

  assign bus.rom_addr = addr_q;
  assign bus.beep     = beep_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.cur_note = note_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      note_q     <= '0;
      beats_left <= '0;
      beat_cnt   <= '0;
      tone_cnt   <= '0;
      half_q     <= '0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        note_q <= '0;
        beep_q <= 1'b0;
      end else if (bus.start) begin
        state  <= ADDR;
        addr_q <= bus.song_base;
        base_q <= bus.song_base;
        note_q <= '0;
        beep_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          ADDR: state <= DATA;
          DATA: begin
            if (note_in != END_NOTE) begin
              note_q     <= note_in;
              half_q     <= half_tab[note_in];
              beats_left <= {1'b0, dur_in} + 4'd1;
              beat_cnt   <= '0;
              tone_cnt   <= '0;
              beep_q     <= 1'b0;
              state      <= PLAY;
            end else if (bus.loop_en) begin
              addr_q <= base_q;
              state  <= ADDR;
            end else begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
          PLAY: begin
            if (half_q != 32'd0) begin
              if (tone_cnt == half_q - 32'd1) begin
                tone_cnt <= '0;
                beep_q   <= ~beep_q;
              end else begin
                tone_cnt <= tone_cnt + 32'd1;
              end
            end else begin
              beep_q <= 1'b0;
            end
            // The beat boundary overrides the tone toggle on the last cycle.
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (beats_left == 4'd1) begin
                addr_q <= addr_q + ADDR_W'(1);
                note_q <= '0;
                beep_q <= 1'b0;
                state  <= ADDR;
              end else begin
                beats_left <= beats_left - 4'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_music_player.sv
// Randomised scoreboard bench for music_player: per-address segments
// are predicted from the score and compared by a free-running monitor.
module tb_music_player;
  localparam int CLK_HZ  = 100_000;
  localparam int TICK_HZ = 100;
  localparam int BEAT    = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  music_player_if #(.ADDR_W(8)) bus ();
  music_player_if #(.ADDR_W(2)) bus2 ();

  music_player #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .ADDR_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  music_player #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .ADDR_W (2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  logic [7:0] rom  [256];
  logic [7:0] rom2 [4];

  always @(posedge clk) bus.rom_data  <= rom[bus.rom_addr];
  always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];

  typedef struct {
    int addr;
    int len;
    int note;
    int rises;
    int first;
    int last;
    int dn;
  } seg_t;

  seg_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   ignore = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int half_ref(input int n);
    int f [22] = '{0, 262, 294, 330, 349, 392, 440, 494,
                   523, 587, 659, 698, 784, 880, 988,
                   1047, 1175, 1319, 1397, 1568, 1760, 1976};
    if (n >= 1 && n <= 21) return CLK_HZ / (2 * f[n]);
    return 0;
  endfunction

  // Walk the score as a listener would hear it, one segment per word.
  task automatic model(input int base, input bit loop, input int max_segs);
    int a;
    int n;
    int note;
    int p;
    int h;
    logic [7:0] w;
    seg_t s;
    a = base;
    n = 0;
    while (n < max_segs) begin
      w = rom[a];
      note = int'(w[7:3]);
      s.addr = a;
      n++;
      if (note == 31) begin
        s.len = 2; s.note = 0; s.rises = 0;
        s.first = -1; s.last = -1; s.dn = loop ? 0 : 1;
        exp_q.push_back(s);
        if (!loop) break;
        a = base;
      end else begin
        p = (int'(w[2:0]) + 1) * BEAT;
        h = half_ref(note);
        s.len = p + 2;
        s.note = note;
        s.dn = 0;
        if (h > 0) begin
          s.rises = ((p - 1) / h + 1) / 2;
          s.first = 2 + h;
          s.last  = 2 + h * (2 * s.rises - 1);
        end else begin
          s.rises = 0; s.first = -1; s.last = -1;
        end
        exp_q.push_back(s);
        a = (a + 1) % 256;
      end
    end
  endtask

  int seg_on = 0;
  int s_addr, s_len, s_note, s_rises, s_first, s_last, s_taint;
  int prev_beep = 0;
  int prev_done = 0;

  task automatic compare_seg(input int dn);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected segment: addr %0d len %0d", s_addr, s_len);
      return;
    end
    e = exp_q.pop_front();
    chk("seg addr", s_addr, e.addr);
    chk("seg len", s_len, e.len);
    chk("seg cur_note", s_note, e.note);
    chk("seg beep rises", s_rises, e.rises);
    chk("seg first rise", s_first, e.first);
    chk("seg last rise", s_last, e.last);
    chk("seg done", dn, e.dn);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      chk("done width", prev_done, 0);
      chk("done while busy", int'(bus.busy), 0);
    end
    prev_done = int'(bus.done);
    if (seg_on != 0 && (!bus.busy || int'(bus.rom_addr) != s_addr)) begin
      seg_on = 0;
      if (s_taint == 0) compare_seg(int'(bus.done && !bus.busy));
    end
    if (bus.busy && seg_on == 0) begin
      seg_on = 1; s_addr = int'(bus.rom_addr); s_len = 0; s_note = 0;
      s_rises = 0; s_first = -1; s_last = -1; s_taint = 0; prev_beep = 0;
    end
    if (seg_on != 0) begin
      if (ignore) s_taint = 1;
      if (int'(bus.cur_note) > s_note) s_note = int'(bus.cur_note);
      if (bus.beep && prev_beep == 0) begin
        s_rises++;
        if (s_first < 0) s_first = s_len;
        s_last = s_len;
      end
      prev_beep = int'(bus.beep);
      s_len++;
    end
  end

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
  endtask

  task automatic play(input int base, input bit loop, input int segs,
                      input string name);
    int budget;
    int c;
    model(base, loop, segs);
    budget = 50;
    foreach (exp_q[i]) budget += exp_q[i].len;
    bus.loop_en = loop;
    bus.song_base = 8'(base);
    pulse_start();
    c = 0;
    while ((exp_q.size() != 0 || (!loop && bus.busy)) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, " timeout"}, int'(c >= budget), 0);
    if (c >= budget) exp_q.delete();
    if (loop || c >= budget) begin
      ignore = 1'b1;
      pulse_stop();
      repeat (3) @(negedge clk);
      ignore = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    bus.song_base = '0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.loop_en = 1'b0;
    bus2.song_base = '0;
    foreach (rom[i]) rom[i] = 8'hF8;
    foreach (rom2[i]) rom2[i] = 8'hF8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rom_addr", int'(bus.rom_addr), 0);
    chk("reset beep", int'(bus.beep), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset cur_note", int'(bus.cur_note), 0);

    rom[0] = 8'h31; rom[1] = 8'hF8;
    play(0, 1'b0, 100, "single note");

    rom[0] = 8'h00; rom[1] = 8'hC8; rom[2] = 8'h68; rom[3] = 8'hF8;
    play(0, 1'b0, 100, "rest invalid");

    rom[4] = 8'h68; rom[5] = 8'hF8;
    play(4, 1'b1, 6, "loop");

    for (int r = 0; r < 6; r++) begin
      int b;
      int n;
      b = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++)
        rom[(b + i) % 256] = {5'($urandom_range(0, 30)),
                              3'($urandom_range(0, 1))};
      rom[(b + n) % 256] = {5'd31, 3'($urandom_range(0, 7))};
      if (r == 5) play(b, 1'b1, 2 * (n + 1), "random loop");
      else play(b, 1'b0, 100, "random song");
    end

    ignore = 1'b1;
    rom[0] = 8'h31; rom[1] = 8'hF8;
    bus.loop_en = 1'b0; bus.song_base = 8'd0;
    pulse_start();
    repeat (350) @(negedge clk);
    chk("pre-stop beep", int'(bus.beep), 1);
    pulse_stop();
    chk("stop beep", int'(bus.beep), 0);
    chk("stop busy", int'(bus.busy), 0);
    chk("stop cur_note", int'(bus.cur_note), 0);
    chk("stop done", int'(bus.done), 0);

    @(negedge clk) begin bus.start = 1'b1; bus.stop = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    chk("start+stop busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    chk("start+stop idle", int'(bus.busy), 0);

    pulse_start();
    repeat (120) @(negedge clk);
    chk("pre-restart beep", int'(bus.beep), 1);
    bus.song_base = 8'd4;
    pulse_start();
    chk("restart rom_addr", int'(bus.rom_addr), 4);
    chk("restart busy", int'(bus.busy), 1);
    chk("restart cur_note", int'(bus.cur_note), 0);
    chk("restart beep", int'(bus.beep), 0);
    pulse_stop();
    repeat (3) @(negedge clk);

    rom[8] = 8'h31; rom[9] = 8'hF8;
    bus.song_base = 8'd8;
    pulse_start();
    repeat (350) @(negedge clk);
    chk("pre-reset beep", int'(bus.beep), 1);
    chk("pre-reset rom_addr", int'(bus.rom_addr), 8);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst rom_addr", int'(bus.rom_addr), 0);
    chk("async rst beep", int'(bus.beep), 0);
    chk("async rst busy", int'(bus.busy), 0);
    chk("async rst done", int'(bus.done), 0);
    chk("async rst cur_note", int'(bus.cur_note), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post-reset idle", int'(bus.busy), 0);
    chk("post-reset rom_addr", int'(bus.rom_addr), 0);
    ignore = 1'b0;

    rom2[3] = 8'h30; rom2[0] = 8'hF8;
    bus2.song_base = 2'd3;
    @(negedge clk) bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    t = 0;
    while (!bus2.beep && t < 300) begin @(negedge clk); t++; end
    chk("wrap first rise", t, 2 + half_ref(6));
    while (bus2.rom_addr == 2'd3 && t < 1200) begin @(negedge clk); t++; end
    chk("wrap note end", t, 2 + BEAT);
    chk("wrap rom_addr", int'(bus2.rom_addr), 0);
    chk("wrap busy", int'(bus2.busy), 1);
    while (bus2.busy && t < 1300) begin @(negedge clk); t++; end
    chk("wrap done time", t, 4 + BEAT);
    chk("wrap done", int'(bus2.done), 1);
    @(negedge clk);
    chk("wrap done width", int'(bus2.done), 0);

    repeat (5) @(negedge clk);
    chk("leftover expected segments", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
